ao_delay_gate: RTL and testbench



---
 rtl/ao_delay_pkg.sv | 19 +
 rtl/inertial_dly_stage.sv | 69 ++++++
 rtl/ao_delay_gate.sv | 71 +++++++
 tb/tb_ao_delay_gate.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ao_delay_pkg.sv
// ao_delay_pkg
//   Shared constants and helpers for the ao_delay_gate gate primitive.
//   - AO_AND_RISE_DLY / AO_AND_FALL_DLY : default AND-stage delays (cycles)
//   - AO_OR_DLY                         : default OR-stage delay (cycles)
//   - ao_cnt_width()                    : bits needed to count up to a delay
package ao_delay_pkg;

  localparam int AO_AND_RISE_DLY = 7;
  localparam int AO_AND_FALL_DLY = 5;
  localparam int AO_OR_DLY       = 12;

  // Width of a counter that must hold values 0..max_dly. Never below 1 bit.
  function automatic int ao_cnt_width(input int max_dly);
    int w;
    w = $clog2(max_dly + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/inertial_dly_stage.sv
// inertial_dly_stage
//   One inertial-delay stage: q follows d only after d has differed from q
//   for D consecutive rising edges (D = RISE_DLY when d = 1, FALL_DLY when
//   d = 0). Any shorter excursion is swallowed.
// Parameters:
//   RISE_DLY, FALL_DLY : delays in cycles, both must be >= 1
// Ports:
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset (q = 0, counter = 0)
//   d       in  stage input
//   q       out delayed stage output (registered)
//   pending out counter nonzero: a transition is in flight
import ao_delay_pkg::*;

module inertial_dly_stage #(
  parameter int RISE_DLY = AO_AND_RISE_DLY,
  parameter int FALL_DLY = AO_AND_FALL_DLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic pending
);

  localparam int CNT_W = ao_cnt_width((RISE_DLY > FALL_DLY) ? RISE_DLY : FALL_DLY);
  localparam logic [CNT_W-1:0] RISE_C = CNT_W'(RISE_DLY);
  localparam logic [CNT_W-1:0] FALL_C = CNT_W'(FALL_DLY);

  // A zero delay would let the counter never match; refuse to elaborate.
  if (RISE_DLY < 1 || FALL_DLY < 1) begin : g_bad_dly
    $error("inertial_dly_stage: delay parameters must be >= 1");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] dly;
  logic             q_nxt;

  // The edge that brings the count to D is the edge on which q updates,
  // so we compare the incremented value rather than the current one.
  always_comb begin
    cnt_inc = cnt + 1'b1;
    dly     = d ? RISE_C : FALL_C;
    q_nxt   = q;
    cnt_nxt = '0;
    if (d != q) begin
      if (cnt_inc == dly) begin
        q_nxt = d;
      end else begin
        cnt_nxt = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      q   <= q_nxt;
    end
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/ao_delay_gate.sv
// ao_delay_gate
//   Clocked model of w = (a & b) | c with inertial delays in whole cycles:
//   an AND stage (asymmetric rise/fall) cascaded into an OR stage
//   (symmetric). All outputs are registered; no input reaches w
//   combinationally.
// Parameters:
//   AND_RISE_DLY (7), AND_FALL_DLY (5), OR_DLY (12) : delays in cycles
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   a, b  in  AND operands
//   c     in  OR operand (direct path)
//   w     out delayed (a & b) | c
//   busy  out (only with AO_BUSY_EN defined) a transition is pending in
//             either stage
// Build option: define AO_BUSY_EN to add the busy output.
import ao_delay_pkg::*;

module ao_delay_gate #(
  parameter int AND_RISE_DLY = AO_AND_RISE_DLY,
  parameter int AND_FALL_DLY = AO_AND_FALL_DLY,
  parameter int OR_DLY       = AO_OR_DLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic w
`ifdef AO_BUSY_EN
  ,
  output logic busy
`endif
);

  logic and_q;
  logic and_pend;
  logic or_pend;

  inertial_dly_stage #(
    .RISE_DLY (AND_RISE_DLY),
    .FALL_DLY (AND_FALL_DLY)
  ) u_and_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (a & b),
    .q       (and_q),
    .pending (and_pend)
  );

  // and_q keeps tracking a & b even while c = 1 masks it at w.
  inertial_dly_stage #(
    .RISE_DLY (OR_DLY),
    .FALL_DLY (OR_DLY)
  ) u_or_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (and_q | c),
    .q       (w),
    .pending (or_pend)
  );

`ifdef AO_BUSY_EN
  // Both counters are held at zero in reset, so busy is 0 there too.
  assign busy = and_pend | or_pend;
`else
  logic unused_pend;
  assign unused_pend = and_pend | or_pend;
`endif

endmodule

// File: tb/tb_ao_delay_gate.sv
// tb_ao_delay_gate
//   Directed bench for ao_delay_gate with default delays (7/5/12).
//   Vector table: each record applies {a,b,c}, advances a number of rising
//   edges, then compares w against a hand-computed value. Hand-written
//   sequences cover masking, count restart and reset mid-transition.
module tb_ao_delay_gate;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic c;
  logic w;
`ifdef AO_BUSY_EN
  logic busy;
`endif

  ao_delay_gate dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .w     (w)
`ifdef AO_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic a;
    logic b;
    logic c;
    int   steps;
    logic exp_w;
  } vec_t;

  vec_t       vecs[$];
  logic [0:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ia, input logic ib, input logic ic);
    a = ia;
    b = ib;
    c = ic;
  endtask

  task automatic add_vec(input logic ia, input logic ib, input logic ic,
                         input int n, input logic e);
    vec_t v;
    v.a = ia; v.b = ib; v.c = ic; v.steps = n; v.exp_w = e;
    vecs.push_back(v);
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk_w(input string name, input int id, input logic e);
    n_vec++;
    if (w !== e) begin
      n_err++;
      $display("FAIL %s[%0d]: w=%b expected %b at %0t", name, id, w, e, $time);
    end
  endtask

`ifdef AO_BUSY_EN
  task automatic chk_busy(input string name, input int id, input logic e);
    n_vec++;
    if (busy !== e) begin
      n_err++;
      $display("FAIL %s[%0d]: busy=%b expected %b at %0t", name, id, busy, e, $time);
    end
  endtask
`endif

  // ---------------- test ----------------
  initial begin
    logic [0:0] e;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    step(3);
    chk_w("reset", 0, 1'b0);
`ifdef AO_BUSY_EN
    chk_busy("reset_busy", 0, 1'b0);
`endif
    rst_n = 1'b1;

    // idle 40 cycles
    add_vec(0, 0, 0, 20, 0);
    add_vec(0, 0, 0, 20, 0);
    // c alone: rise on edge 12, fall 12 edges after clearing at +30
    add_vec(0, 0, 1, 11, 0);
    add_vec(0, 0, 1,  1, 1);
    add_vec(0, 0, 1, 18, 1);
    add_vec(0, 0, 0, 11, 1);
    add_vec(0, 0, 0,  1, 0);
    // a & b rising: 19 edges; falling: 17 edges
    add_vec(0, 1, 0,  5, 0);
    add_vec(1, 1, 0, 18, 0);
    add_vec(1, 1, 0,  1, 1);
    add_vec(1, 1, 0, 11, 1);
    add_vec(1, 0, 0, 16, 1);
    add_vec(1, 0, 0,  1, 0);
    add_vec(1, 0, 0,  5, 0);
    // a & b pulse of 6 edges (one short of rise delay) is swallowed
    add_vec(1, 1, 0,  6, 0);
    add_vec(1, 0, 0, 25, 0);
    // c pulse of 5 edges is swallowed
    add_vec(1, 0, 1,  5, 0);
    add_vec(1, 0, 0, 20, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c);
      step(vecs[i].steps);
      e = exp_q.pop_front();
      chk_w("vec", i, e);
    end

    // masking: with c = 1 and w = 1, a & b going 0->1->0 leaves w at 1
    drive(1'b1, 1'b0, 1'b1);
    step(12);
    chk_w("mask_up", 0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk_w("mask_hi", i, 1'b1);
    end
    drive(1'b1, 0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk_w("mask_lo", i, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    step(11);
    chk_w("mask_dn", 0, 1'b1);
    step(1);
    chk_w("mask_dn", 1, 1'b0);

    // count restart: c drops for one edge at count 8, then needs 12 fresh edges
    drive(1'b0, 1'b0, 1'b1);
    step(8);
    drive(1'b0, 1'b0, 1'b0);
    step(1);
    drive(1'b0, 1'b0, 1'b1);
    step(11);
    chk_w("restart", 0, 1'b0);
    step(1);
    chk_w("restart", 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    step(12);
    chk_w("restart", 2, 1'b0);

    // reset at count 6 of a c rise abandons it; after release 12 edges again
    drive(1'b0, 1'b0, 1'b1);
    step(6);
    rst_n = 1'b0;
    #1;
    chk_w("rst_mid", 0, 1'b0);
    step(2);
    chk_w("rst_mid", 1, 1'b0);
    rst_n = 1'b1;
    step(11);
    chk_w("rst_mid", 2, 1'b0);
    step(1);
    chk_w("rst_mid", 3, 1'b1);
    // reset while w = 1 clears it without waiting for an edge
    rst_n = 1'b0;
    #1;
    chk_w("rst_hi", 0, 1'b0);
    step(1);
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3);

`ifdef AO_BUSY_EN
    // busy follows a 5-edge c pulse exactly
    chk_busy("busy_idle", 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_busy("busy_pulse", i, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0);
    step(1);
    chk_busy("busy_end", 0, 1'b0);
    chk_w("busy_end", 1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
